// File: rtl/bcd_2_bin_pkg.sv
// Shared state encoding, sizing constants and digit-range helper for the BCD to binary converter.
package bcd_2_bin_pkg;

    localparam int DIGITS = 3;
    localparam int BIN_W  = 10;
    localparam int N_ITER = 10;
    localparam int DIG_W  = DIGITS * 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_OP   = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic any_digit_invalid(input logic [DIG_W-1:0] digits);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digits[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Reverse double-dabble digit correction: subtracts 3 from a shifted digit that landed at 8 or above.
module bcd_digit_adj (
    input  logic [3:0] i_dig,
    output logic [3:0] o_dig
);

    assign o_dig = (i_dig >= 4'd8) ? (i_dig - 4'd3) : i_dig;

endmodule

// File: rtl/bcd_2_bin.sv
// Three-digit BCD to 10-bit binary converter using iterative reverse double-dabble.
// Valid requests take 10 op cycles then one done cycle; out-of-range digits skip straight to done with err set.
module bcd_2_bin
    import bcd_2_bin_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       bcd2,
    input  logic [3:0]       bcd1,
    input  logic [3:0]       bcd0,
    output logic             ready,
    output logic             done_tick,
    output logic             err,
    output logic [BIN_W-1:0] bin
);

    state_t             r_state;
    state_t             w_state_next;
    logic [DIG_W-1:0]   r_digits;
    logic [DIG_W-1:0]   w_digits_next;
    logic [BIN_W-1:0]   r_bin;
    logic [BIN_W-1:0]   w_bin_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic [CNT_W-1:0]   w_cnt_dec;
    logic               r_err;
    logic               w_err_next;

    logic [DIG_W-1:0]       w_in_digits;
    logic                   w_in_bad;
    logic [DIG_W+BIN_W-1:0] w_shift;
    logic [DIG_W-1:0]       w_adj;

    assign w_in_digits = {bcd2, bcd1, bcd0};
    assign w_in_bad    = any_digit_invalid(w_in_digits);
    assign w_cnt_dec   = r_cnt - 4'd1;

    // Digits and binary accumulator shift as one word so the units LSB falls into bin[MSB].
    assign w_shift = {r_digits, r_bin} >> 1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_dig (w_shift[BIN_W + 4*g +: 4]),
            .o_dig (w_adj[4*g +: 4])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = w_in_bad ? ST_DONE : ST_OP;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_OP:   w_state_next = (w_cnt_dec == '0) ? ST_DONE : ST_OP;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ready     = (r_state == ST_IDLE);
        done_tick = (r_state == ST_DONE);
    end

    always_comb begin
        w_digits_next = r_digits;
        w_bin_next    = r_bin;
        w_cnt_next    = r_cnt;
        w_err_next    = r_err;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_digits_next = w_in_digits;
                    w_bin_next    = '0;
                    w_cnt_next    = CNT_W'(N_ITER);
                    w_err_next    = w_in_bad;
                end
            end
            ST_OP: begin
                w_digits_next = w_adj;
                w_bin_next    = w_shift[BIN_W-1:0];
                w_cnt_next    = w_cnt_dec;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_digits <= '0;
            r_bin    <= '0;
            r_cnt    <= '0;
            r_err    <= 1'b0;
        end else begin
            r_digits <= w_digits_next;
            r_bin    <= w_bin_next;
            r_cnt    <= w_cnt_next;
            r_err    <= w_err_next;
        end
    end

    assign err = r_err;
    assign bin = r_bin;

    // Every valid digit must have been fully drained into bin by the time done is reached.
    a_digits_drained: assert property (@(posedge clk) disable iff (reset)
        (r_state == ST_DONE && !r_err) |-> (r_digits == '0));

endmodule

// File: tb/tb_bcd_2_bin.sv
// Directed-vector bench for bcd_2_bin: latency, results, error path, mid-op reset and held start.
module tb_bcd_2_bin;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] bcd2;
    logic [3:0] bcd1;
    logic [3:0] bcd0;
    logic       ready;
    logic       done_tick;
    logic       err;
    logic [9:0] bin;

    int n_tests;
    int n_fail;

    bcd_2_bin dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bcd2      (bcd2),
        .bcd1      (bcd1),
        .bcd0      (bcd0),
        .ready     (ready),
        .done_tick (done_tick),
        .err       (err),
        .bin       (bin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one conversion and measure latency to done_tick; start is pulsed again mid-op with noise digits.
    task automatic conv(input string tag, input logic [3:0] d2, input logic [3:0] d1,
                        input logic [3:0] d0, input int exp_bin, input int exp_err,
                        input int exp_lat);
        int lat;
        chk({tag, "_ready"}, int'(ready), 1);
        bcd2  = d2;
        bcd1  = d1;
        bcd0  = d0;
        start = 1'b1;
        tick();
        start = 1'b0;
        bcd2  = 4'h7;
        bcd1  = 4'h7;
        bcd0  = 4'h7;
        lat   = 1;
        while (!done_tick && lat < 20) begin
            start = (lat >= 3 && lat <= 5);
            tick();
            lat++;
        end
        start = 1'b0;
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_bin"}, int'(bin), exp_bin);
        chk({tag, "_err"}, int'(err), exp_err);
        tick();
        chk({tag, "_tick_1cyc"}, int'(done_tick), 0);
        chk({tag, "_ready_after"}, int'(ready), 1);
    endtask

    initial begin
        int n_done;
        int first_done;
        int second_done;
        int bin_first;
        int bin_second;

        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        start   = 1'b0;
        bcd2    = 4'h0;
        bcd1    = 4'h0;
        bcd0    = 4'h0;

        repeat (2) tick();
        chk("rst_ready", int'(ready), 1);
        chk("rst_done", int'(done_tick), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_bin", int'(bin), 0);
        reset = 1'b0;
        tick();

        conv("c999", 4'd9, 4'd9, 4'd9, 999, 0, 11);
        conv("c000", 4'd0, 4'd0, 4'd0, 0, 0, 11);
        conv("c512", 4'd5, 4'd1, 4'd2, 512, 0, 11);
        repeat (3) begin
            tick();
            chk("hold512", int'(bin), 512);
        end
        conv("c128", 4'd1, 4'd2, 4'd8, 128, 0, 11);

        conv("cbad", 4'hA, 4'd0, 4'd1, 0, 1, 1);
        tick();
        chk("hold_err", int'(err), 1);
        conv("c042", 4'd0, 4'd4, 4'd2, 42, 0, 11);

        // Abort in the 5th op cycle; bin is partially shifted (nonzero) at that point.
        bcd2  = 4'd9;
        bcd1  = 4'd9;
        bcd0  = 4'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("midop_ready_before", int'(ready), 0);
        reset = 1'b1;
        #1;
        chk("midop_rst_ready", int'(ready), 1);
        chk("midop_rst_bin", int'(bin), 0);
        chk("midop_rst_done", int'(done_tick), 0);
        tick();
        reset  = 1'b0;
        n_done = 0;
        for (int i = 0; i < 14; i++) begin
            if (done_tick) n_done++;
            tick();
        end
        chk("midop_no_done", n_done, 0);
        conv("c307", 4'd3, 4'd0, 4'd7, 307, 0, 11);

        // Start held for 30 cycles: accepted only on idle cycles.
        bcd2        = 4'd0;
        bcd1        = 4'd6;
        bcd0        = 4'd3;
        start       = 1'b1;
        n_done      = 0;
        first_done  = -1;
        second_done = -1;
        bin_first   = -1;
        bin_second  = -1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (done_tick) begin
                n_done++;
                if (n_done == 1) begin
                    first_done = c;
                    bin_first  = int'(bin);
                end else if (n_done == 2) begin
                    second_done = c;
                    bin_second  = int'(bin);
                end
            end
            if (c == 12) chk("held_ready12", int'(ready), 1);
            if (c == 13) chk("held_ready13", int'(ready), 0);
        end
        start = 1'b0;
        chk("held_n_done", n_done, 2);
        chk("held_first", first_done, 11);
        chk("held_second", second_done, 23);
        chk("held_bin1", bin_first, 63);
        chk("held_bin2", bin_second, 63);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_2_bin.md
BCD_2_BIN -- requirements
Module: bcd_2_bin

Interface
REQ-001 The block SHALL have the following ports, named exactly as listed; reset is asynchronous and active-high, and the clock is clk:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  conversion request; sampled only while ready=1.
- bcd2  input  4  hundreds digit; sampled on the start edge.
- bcd1  input  4  tens digit; sampled on the start edge.
- bcd0  input  4  units digit; sampled on the start edge.
- ready  output  1  high in idle state only (combinational from state).
- done_tick  output  1  one-cycle pulse in done state (combinational from state).
- err  output  1  registered; high when the last accepted request held a digit >9.
- bin  output  10  registered binary result of the last accepted request.

Function
REQ-002 The FSM SHALL have three states: idle, op and done; the default branch SHALL go to idle.
REQ-003 In idle with start=1, the next edge SHALL load bcd2/bcd1/bcd0 into a 12-bit digit register, clear the bin register, load the iteration counter with 10 and go to op.
REQ-004 If any sampled digit is >9 on the start edge, that edge SHALL set err=1, load bin=0 and go directly to done, skipping op.
REQ-005 Otherwise that edge SHALL clear err to 0.
REQ-006 Each op cycle SHALL shift {digit register, bin register} right by one bit as a single 22-bit shift, so that bit0 of bcd0 enters bin[9].
REQ-007 In the same op cycle, each shifted 4-bit digit with value >=8 SHALL have 3 subtracted (reverse double-dabble); digits <8 SHALL pass unchanged.
REQ-008 The counter SHALL decrement by 1 each op cycle; when the decremented value is 0, the FSM SHALL go to done.
REQ-009 For a valid request, op SHALL last exactly 10 cycles; done_tick SHALL be high in the 11th cycle after the start edge and ready high again in the 12th.
REQ-010 For an invalid request, done_tick SHALL be high in the cycle immediately after the start edge.
REQ-011 In the done state the FSM SHALL assert done_tick for one cycle and go to idle unconditionally.
REQ-012 bin SHALL equal 100*bcd2 + 10*bcd1 + bcd0, range 0..999, from the done cycle until the next accepted start.
REQ-013 start SHALL be ignored in op and done.
REQ-014 If start is held high continuously, a new conversion SHALL be accepted on the first idle cycle, i.e. every 12 cycles for valid input.
REQ-015 bin and err SHALL hold their values while idle.
REQ-016 The digit register SHALL be zero after 10 valid iterations; a verification assertion SHALL check this.

Reset
REQ-017 reset=1 SHALL immediately force state=idle and clear the digit register, bin register, counter and err to 0.
REQ-018 While in reset, outputs SHALL be ready=1, done_tick=0, err=0 and bin=0.
REQ-019 A reset asserted mid-op SHALL abort the conversion with no done_tick; the first start after reset release SHALL be accepted normally.

Structure
REQ-020 A shared package SHALL hold the state encoding (idle=2'b00, op=2'b01, done=2'b10) and the constants DIGITS=3, BIN_W=10 and N_ITER=10.
REQ-021 One sub-module, bcd_digit_adj (4-bit in, 4-bit out, subtracts 3 when the input is >=8), SHALL be instantiated once per digit.
REQ-022 State and data registers SHALL be kept separate from the next-state logic.

Verification
REQ-023 The bench SHALL cover: digits 9,9,9 with a start pulse -> done_tick 11 cycles later, bin=999 (10'h3E7), err=0.
REQ-024 The bench SHALL cover: digits 0,0,0 -> bin=0, err=0, done_tick at the same latency.
REQ-025 The bench SHALL cover: digits 5,1,2 -> bin=512; then 1,2,8 -> bin=128, with bin holding 512 until the second start edge.
REQ-026 The bench SHALL cover: digits 0xA,0,1 -> done_tick 1 cycle after start, err=1, bin=0; a following valid 0,4,2 -> err=0, bin=42.
REQ-027 The bench SHALL cover: reset pulsed during the 5th op cycle -> ready=1, bin=0 immediately; no done_tick; the next start with 3,0,7 -> bin=307.
REQ-028 The bench SHALL cover: start held high for 30 cycles with 0,6,3 -> done_tick at cycles 11 and 23, bin=63 each time, with start ignored outside idle.
